// File: rtl/cache_traffic_gen.sv
// cache_traffic_gen
//   LFSR-driven stimulus generator and self-checker for the CPU side of a cache.
//   Each run issues NUM_TXN random reads/writes and waits for mem_resp on each one.
//   A per-byte shadow of written data is used to check read data. A watchdog
//   ends the run if a response never arrives.
// Ports
//   clk, rst            clock; synchronous active-high reset
//   start               pulse that begins a run (only seen in IDLE/DONE)
//   mem_address/wdata/byte_enable/read/write   request to the cache (registered)
//   mem_rdata, mem_resp read data and completion from the cache
//   busy, done          run in progress / run finished (held)
//   error, timeout      sticky per-run flags
//   txn_count           completed transactions this run
//   err_count           read mismatches this run (saturating)
module cache_traffic_gen #(
   parameter int unsigned NUM_TXN   = 256,
   parameter logic [31:0] SEED      = 32'hACE12345,
   parameter int unsigned MODE      = 2,
   parameter int unsigned ADDR_BITS = 9,
   parameter logic [31:0] BASE_ADDR = 32'h0,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [31:0] mem_address,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_byte_enable,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_rdata,
   input  logic        mem_resp,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic        timeout,
   output logic [15:0] txn_count,
   output logic [15:0] err_count
);

   localparam int unsigned WORDS    = 32'd1 << (ADDR_BITS - 32'd2);
   localparam logic [31:0] TAPS     = 32'h80200003;
   localparam logic [15:0] LAST_TXN = 16'(NUM_TXN);
   localparam logic [31:0] WD_LAST  = 32'(TIMEOUT - 32'd1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // One step of the right-shifting Galois LFSR.
   function automatic logic [31:0] lfsr_step(input logic [31:0] l);
      lfsr_step = {1'b0, l[31:1]} ^ (l[0] ? TAPS : 32'h0);
   endfunction

   // True when any byte that the shadow knows about differs from the read data.
   function automatic logic bytes_differ(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] valid);
      bytes_differ = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (valid[i] && (a[8*i +: 8] != b[8*i +: 8])) begin
            bytes_differ = 1'b1;
         end
      end
   endfunction

   state_t                 state_r, state_nx_s;
   logic [31:0]            lfsr_r, lfsr_adv_s;
   logic [31:0]            wd_cnt_r;
   logic [3:0]             sh_valid_r [WORDS];
   logic [31:0]            sh_data_r  [WORDS];
   logic [ADDR_BITS-3:0]   idx_s;
   logic                   run_start_s, load_s, resp_s, last_s, wd_fire_s, mismatch_s;
   logic                   op_wr_ld_s;
   logic [31:0]            addr_ld_s, wdata_ld_s;
   logic [3:0]             be_ld_s;

   assign lfsr_adv_s  = lfsr_step(lfsr_r);
   assign idx_s       = mem_address[ADDR_BITS-1:2];
   assign run_start_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
   assign load_s      = run_start_s || (state_r == ST_GAP);
   assign resp_s      = (state_r == ST_REQ) && mem_resp;
   assign last_s      = (txn_count + 16'd1) == LAST_TXN;
   // A response arriving in the final watchdog cycle still counts as a normal completion.
   assign wd_fire_s   = (state_r == ST_REQ) && !mem_resp && (wd_cnt_r == WD_LAST);
   assign mismatch_s  = bytes_differ(mem_rdata, sh_data_r[idx_s], sh_valid_r[idx_s]);

   // Next-state logic of the run controller.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_nx_s = ST_REQ;
            end else begin
               state_nx_s = state_r;
            end
         end
         ST_REQ: begin
            if (mem_resp) begin
               state_nx_s = last_s ? ST_DONE : ST_GAP;
            end else if (wd_fire_s) begin
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_REQ;
            end
         end
         ST_GAP:  state_nx_s = ST_REQ;
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // Transaction fields decoded from the freshly advanced LFSR value.
   always_comb begin
      op_wr_ld_s = 1'b0;
      be_ld_s    = 4'hF;
      if (MODE == 32'd0) begin
         op_wr_ld_s = 1'b0;
      end else if (MODE == 32'd1) begin
         op_wr_ld_s = 1'b1;
      end else begin
         op_wr_ld_s = lfsr_adv_s[0];
      end
      if (op_wr_ld_s && (lfsr_adv_s[7:4] != 4'h0)) begin
         be_ld_s = lfsr_adv_s[7:4];
      end else begin
         be_ld_s = 4'hF;
      end
      addr_ld_s  = BASE_ADDR | 32'({lfsr_adv_s[ADDR_BITS-1:2], 2'b00});
      wdata_ld_s = {lfsr_adv_s[15:0], lfsr_adv_s[31:16]};
   end

   // State, LFSR, request outputs, watchdog, counters, flags and shadow valid bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r         <= ST_IDLE;
         lfsr_r          <= SEED;
         wd_cnt_r        <= 32'd0;
         mem_address     <= 32'h0;
         mem_wdata       <= 32'h0;
         mem_byte_enable <= 4'h0;
         mem_read        <= 1'b0;
         mem_write       <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         error           <= 1'b0;
         timeout         <= 1'b0;
         txn_count       <= 16'd0;
         err_count       <= 16'd0;
         for (int w = 0; w < int'(WORDS); w++) begin
            sh_valid_r[w] <= 4'h0;
         end
      end else begin
         state_r <= state_nx_s;
         busy    <= (state_nx_s == ST_REQ) || (state_nx_s == ST_GAP);
         done    <= (state_nx_s == ST_DONE);

         if (load_s) begin
            lfsr_r          <= lfsr_adv_s;
            wd_cnt_r        <= 32'd0;
            mem_address     <= addr_ld_s;
            mem_wdata       <= wdata_ld_s;
            mem_byte_enable <= be_ld_s;
            mem_write       <= op_wr_ld_s;
            mem_read        <= !op_wr_ld_s;
         end else if (state_nx_s != ST_REQ) begin
            mem_address     <= 32'h0;
            mem_wdata       <= 32'h0;
            mem_byte_enable <= 4'h0;
            mem_write       <= 1'b0;
            mem_read        <= 1'b0;
         end else begin
            wd_cnt_r <= wd_cnt_r + 32'd1;
         end

         if (run_start_s) begin
            error     <= 1'b0;
            timeout   <= 1'b0;
            txn_count <= 16'd0;
            err_count <= 16'd0;
            for (int w = 0; w < int'(WORDS); w++) begin
               sh_valid_r[w] <= 4'h0;
            end
         end else if (resp_s) begin
            txn_count <= txn_count + 16'd1;
            if (mem_write) begin
               sh_valid_r[idx_s] <= sh_valid_r[idx_s] | mem_byte_enable;
            end else if (mismatch_s) begin
               error <= 1'b1;
               if (err_count != 16'hFFFF) begin
                  err_count <= err_count + 16'd1;
               end
            end
         end else if (wd_fire_s) begin
            timeout <= 1'b1;
            error   <= 1'b1;
         end
      end
   end

   // Shadow data bytes; only meaningful where the matching valid bit is set.
   always_ff @(posedge clk) begin
      if (resp_s && mem_write) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_byte_enable[b]) begin
               sh_data_r[idx_s][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_cache_traffic_gen.sv
module tb_cache_traffic_gen;

   localparam logic [31:0] SEED = 32'hACE12345;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // ---------------- DUT 0: 4 writes, default watchdog ----------------
   logic        rst0, start0, rd0, wr0, resp0, busy0, done0, err0, tmo0;
   logic [31:0] addr0, wdata0, rdata0;
   logic [3:0]  be0;
   logic [15:0] txn0, ecnt0;

   cache_traffic_gen #(.NUM_TXN(4), .SEED(SEED), .MODE(1)) u0 (
      .clk(clk), .rst(rst0), .start(start0),
      .mem_address(addr0), .mem_wdata(wdata0), .mem_byte_enable(be0),
      .mem_read(rd0), .mem_write(wr0), .mem_rdata(rdata0), .mem_resp(resp0),
      .busy(busy0), .done(done0), .error(err0), .timeout(tmo0),
      .txn_count(txn0), .err_count(ecnt0));

   // ---------------- DUT 1: mixed traffic, short watchdog ----------------
   logic        rst1, start1, rd1, wr1, resp1, busy1, done1, err1, tmo1;
   logic [31:0] addr1, wdata1, rdata1;
   logic [3:0]  be1;
   logic [15:0] txn1, ecnt1;

   cache_traffic_gen #(.NUM_TXN(256), .SEED(SEED), .MODE(2), .TIMEOUT(16)) u1 (
      .clk(clk), .rst(rst1), .start(start1),
      .mem_address(addr1), .mem_wdata(wdata1), .mem_byte_enable(be1),
      .mem_read(rd1), .mem_write(wr1), .mem_rdata(rdata1), .mem_resp(resp1),
      .busy(busy1), .done(done1), .error(err1), .timeout(tmo1),
      .txn_count(txn1), .err_count(ecnt1));

   function automatic logic [31:0] lfsr_adv(input logic [31:0] l);
      lfsr_adv = (l >> 1) ^ (l[0] ? 32'h80200003 : 32'h0);
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      int          delay;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } vec_t;

   vec_t tbl[4];
   vec_t sb0[$];

   // Bus model for DUT 1: random-latency byte-enabled memory, request checker.
   logic [31:0] mem1 [128];
   logic [3:0]  wrt1 [128];
   int          resp_mode = 0;   // 0 correct, 1 flip rdata[0] on written words, 2 never respond
   int          flips = 0;
   logic [31:0] lf1 = SEED;

   initial begin
      bit          pending;
      int          cnt;
      logic        ewr;
      logic [3:0]  ebe;
      logic [6:0]  idx;
      pending = 1'b0;
      cnt = 0;
      resp1 = 1'b0;
      rdata1 = 32'h0;
      for (int w = 0; w < 128; w++) mem1[w] = $urandom;
      forever begin
         @(negedge clk);
         resp1 = 1'b0;
         if (rst1) begin
            pending = 1'b0;
         end else if ((rd1 || wr1) && !pending) begin
            pending = 1'b1;
            cnt = $urandom_range(0, 5);
            lf1 = lfsr_adv(lf1);
            ewr = lf1[0];
            ebe = (ewr && lf1[7:4] != 4'h0) ? lf1[7:4] : 4'hF;
            check("u1_req", {rd1, wr1, addr1, be1}, {~ewr, ewr, 23'h0, lf1[8:2], 2'b00, ebe});
            if (ewr) check("u1_wdata", wdata1, {lf1[15:0], lf1[31:16]});
         end
         if (pending && resp_mode != 2) begin
            if (cnt == 0) begin
               idx = addr1[8:2];
               if (wr1) begin
                  for (int b = 0; b < 4; b++) begin
                     if (be1[b]) begin
                        mem1[idx][8*b +: 8] = wdata1[8*b +: 8];
                        wrt1[idx][b] = 1'b1;
                     end
                  end
               end else begin
                  rdata1 = mem1[idx];
                  if (resp_mode == 1 && wrt1[idx][0]) begin
                     rdata1[0] = ~rdata1[0];
                     flips++;
                  end
               end
               resp1 = 1'b1;
               pending = 1'b0;
            end else begin
               cnt--;
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL global_time_limit: got expired expected finished");
      $fatal(1, "time limit");
   end

   task automatic pulse_start0();
      @(negedge clk); start0 = 1'b1;
      @(negedge clk); start0 = 1'b0;
   endtask

   task automatic pulse_start1();
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
   endtask

   task automatic wait_done1(input string name);
      int n;
      n = 0;
      while (!done1 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check(name, done1, 1'b1);
   endtask

   initial begin
      logic [31:0] l;
      vec_t        e;
      logic [68:0] snap;
      int          n;

      // Expected write stream of DUT 0 straight after reset.
      l = SEED;
      for (int i = 0; i < 4; i++) begin
         l = lfsr_adv(l);
         tbl[i].delay = 1;
         tbl[i].addr  = {23'h0, l[8:2], 2'b00};
         tbl[i].be    = (l[7:4] == 4'h0) ? 4'hF : l[7:4];
         tbl[i].wdata = {l[15:0], l[31:16]};
      end

      rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
      resp0 = 1'b0; rdata0 = 32'h0;
      repeat (2) @(negedge clk);
      rst0 = 1'b0; rst1 = 1'b0;

      // Idle after reset: everything low.
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("reset_idle", {addr0, wdata0, be0, rd0, wr0, busy0, done0, err0, tmo0, txn0, ecnt0},
               128'h0);
      end

      // Four writes, response one cycle after the request appears.
      foreach (tbl[i]) sb0.push_back(tbl[i]);
      pulse_start0();
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (!(wr0 || rd0) && n < 50) begin
            @(negedge clk);
            n++;
         end
         check("gap_len", n, (i == 0) ? 0 : 1);
         e = sb0.pop_front();
         check("w_op", {rd0, wr0, busy0}, 3'b011);
         check("w_addr", addr0, e.addr);
         check("w_be", be0, e.be);
         check("w_wdata", wdata0, e.wdata);
         snap = {addr0, wdata0, be0, wr0};
         repeat (e.delay) begin
            @(negedge clk);
            check("w_stable", {addr0, wdata0, be0, wr0}, snap);
         end
         resp0 = 1'b1;
         @(negedge clk);
         resp0 = 1'b0;
         check("w_req_low", {rd0, wr0, busy0}, {2'b00, (i < 3)});
      end
      check("w_done", {done0, busy0, err0, tmo0}, 4'b1000);
      check("w_txn", txn0, 16'd4);
      repeat (3) @(negedge clk);
      check("w_done_held", {done0, txn0}, {1'b1, 16'd4});

      // Reset while a write is outstanding, then restart from the seed.
      pulse_start0();
      check("rst_pre_wr", wr0, 1'b1);
      rst0 = 1'b1;
      @(negedge clk);
      check("rst_wr_low", {wr0, rd0, busy0, done0, txn0}, 20'h0);
      rst0 = 1'b0;
      sb0.push_back(tbl[0]);
      pulse_start0();
      e = sb0.pop_front();
      check("rst_first_addr", {wr0, addr0, be0, wdata0}, {1'b1, e.addr, e.be, e.wdata});
      rst0 = 1'b1;
      @(negedge clk);
      rst0 = 1'b0;

      // Mixed run with a correct memory.
      for (int w = 0; w < 128; w++) wrt1[w] = 4'h0;
      resp_mode = 0;
      pulse_start1();
      wait_done1("mix_done");
      check("mix_txn", txn1, 16'd256);
      check("mix_flags", {err1, tmo1, busy1, ecnt1}, 19'h0);

      // Mixed run with bit 0 corrupted on reads of written words.
      for (int w = 0; w < 128; w++) wrt1[w] = 4'h0;
      flips = 0;
      resp_mode = 1;
      pulse_start1();
      wait_done1("flip_done");
      check("flip_txn", txn1, 16'd256);
      check("flip_ecnt", ecnt1, 16'(flips));
      check("flip_err", {err1, tmo1}, {(flips != 0), 1'b0});

      // No response at all: watchdog after 16 request cycles.
      resp_mode = 2;
      pulse_start1();
      n = 0;
      while ((rd1 || wr1) && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("tmo_req_cycles", n, 16);
      check("tmo_flags", {tmo1, err1, done1, busy1, rd1, wr1}, 6'b111000);
      check("tmo_txn", txn1, 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
